// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// load_store_unit : byte/half/word RAM access stage with ready/valid timeout
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ready,
  output logic              resp_valid,
  output logic [31:0]       load_data,
  output logic              err_misalign,
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       sd_q;
  logic              we_q;
  logic [7:0]        wait_cnt;

  logic        misalign;
  logic        bad_req;
  logic        timeout;
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;

  always_comb begin
    misalign = 1'b0;
    case (size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr[0];
      2'b10:   misalign = |addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  // Anything other than exactly one direction is rejected like a misalignment.
  assign bad_req = misalign || !(mem_read ^ mem_write);
  assign timeout = (wait_cnt == 8'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (req_valid) next_state = bad_req ? S_DONE : S_WAIT;
      S_WAIT:  if (ram_ready || timeout) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q       <= '0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      sd_q         <= '0;
      we_q         <= 1'b0;
      wait_cnt     <= '0;
      load_data    <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q       <= addr;
            size_q       <= size;
            uns_q        <= unsigned_ld;
            sd_q         <= store_data;
            we_q         <= mem_write;
            wait_cnt     <= '0;
            err_misalign <= bad_req;
            err_timeout  <= 1'b0;
            if (bad_req) load_data <= '0;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          // ready takes priority over a coincident timeout
          if (ram_ready) begin
            if (!we_q) load_data <= ld_ext;
          end else if (timeout) begin
            err_timeout <= 1'b1;
            load_data   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = sd_q;
    case (size_q)
      2'b00: begin
        be_raw    = 4'b0001 << addr_q[1:0];
        wdata_raw = {4{sd_q[7:0]}};
      end
      2'b01: begin
        be_raw    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_raw = {2{sd_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = ram_rdata[7:0];
    case (addr_q[1:0])
      2'b00: byte_sel = ram_rdata[7:0];
      2'b01: byte_sel = ram_rdata[15:8];
      2'b10: byte_sel = ram_rdata[23:16];
      2'b11: byte_sel = ram_rdata[31:24];
      default: ;
    endcase
    half_sel = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    ld_ext   = ram_rdata;
    case (size_q)
      2'b00:   ld_ext = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
      2'b01:   ld_ext = {{16{half_sel[15] & ~uns_q}}, half_sel};
      default: ld_ext = ram_rdata;
    endcase
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign ram_en     = (state == S_WAIT);
  assign ram_we     = ram_en & we_q;
  assign ram_addr   = ram_en ? addr_q[ADDR_W-1:2] : '0;
  assign ram_be     = ram_en ? be_raw : 4'b0000;
  assign ram_wdata  = (ram_en && we_q) ? wdata_raw : '0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//------------------------------------------------------------------------------
// tb_load_store_unit : directed self-checking bench for load_store_unit
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

  localparam int ADDR_W   = 10;
  localparam int MAX_WAIT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       store_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-3:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_ready;
  logic              resp_valid;
  logic [31:0]       load_data;
  logic              err_misalign;
  logic              err_timeout;

  int errors = 0;
  int checks = 0;
  int en_cycles;
  bit resp_seen;

  load_store_unit #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .store_data(store_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .resp_valid(resp_valid), .load_data(load_data),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request in IDLE; returns 1ns after the accepting edge.
  task automatic issue(input bit rd, input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [ADDR_W-1:0] a,
                       input logic [31:0] sd);
    req_valid   = 1'b1;
    mem_read    = rd;
    mem_write   = wr;
    size        = sz;
    unsigned_ld = uns;
    addr        = a;
    store_data  = sd;
    step();
    req_valid   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
  endtask

  // Raise ram_ready in WAIT cycle number ready_after (0 = never) and wait for resp_valid.
  task automatic run_wait(input int ready_after, output int en_cnt);
    bit got;
    got    = 1'b0;
    en_cnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      if (ram_en) en_cnt++;
      ram_ready = (ready_after != 0) && (cyc >= ready_after);
      step();
    end
    ram_ready = 1'b0;
    check("resp_seen", 32'(got), 32'd1);
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    size        = 2'b00;
    unsigned_ld = 1'b0;
    addr        = '0;
    store_data  = '0;
    ram_rdata   = '0;
    ram_ready   = 1'b0;

    repeat (3) step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_be", 32'(ram_be), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_errs", {30'd0, err_misalign, err_timeout}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Signed byte load from lane 3
    ram_rdata = 32'h80112233;
    issue(1, 0, 2'b00, 0, 10'h007, 32'hFFFF_FFFF);
    check("lb_ram_en", 32'(ram_en), 32'd1);
    check("lb_ram_we", 32'(ram_we), 32'd0);
    check("lb_ram_be", 32'(ram_be), 32'h8);
    check("lb_ram_addr", 32'(ram_addr), 32'h1);
    check("lb_ram_wdata", ram_wdata, 32'd0);
    run_wait(1, en_cycles);
    check("lb_en_cycles", 32'(en_cycles), 32'd1);
    check("lb_load_data", load_data, 32'hFFFFFF80);
    check("lb_errs", {30'd0, err_misalign, err_timeout}, 32'd0);
    step();

    // Unsigned byte load
    issue(1, 0, 2'b00, 1, 10'h007, 32'h0);
    run_wait(1, en_cycles);
    check("lbu_load_data", load_data, 32'h00000080);
    step();

    // Word store; load_data must be left alone
    issue(0, 1, 2'b10, 0, 10'h010, 32'hDEADBEEF);
    check("sw_ram_en", 32'(ram_en), 32'd1);
    check("sw_ram_we", 32'(ram_we), 32'd1);
    check("sw_ram_addr", 32'(ram_addr), 32'h04);
    check("sw_ram_be", 32'(ram_be), 32'hF);
    check("sw_ram_wdata", ram_wdata, 32'hDEADBEEF);
    check("sw_req_ready", 32'(req_ready), 32'd0);
    check("sw_resp_early", 32'(resp_valid), 32'd0);
    ram_ready = 1'b1;
    step();
    ram_ready = 1'b0;
    check("sw_resp_valid", 32'(resp_valid), 32'd1);
    check("sw_ram_en_done", 32'(ram_en), 32'd0);
    check("sw_errs", {30'd0, err_misalign, err_timeout}, 32'd0);
    check("sw_load_kept", load_data, 32'h00000080);
    step();
    check("sw_resp_pulse", 32'(resp_valid), 32'd0);
    check("sw_req_ready_back", 32'(req_ready), 32'd1);

    // Half and byte stores: lane steering
    issue(0, 1, 2'b01, 0, 10'h006, 32'h1234BEEF);
    check("sh_ram_be", 32'(ram_be), 32'hC);
    check("sh_ram_wdata", ram_wdata, 32'hBEEFBEEF);
    run_wait(1, en_cycles);
    step();
    issue(0, 1, 2'b00, 0, 10'h005, 32'h000000A5);
    check("sb_ram_be", 32'(ram_be), 32'h2);
    check("sb_ram_wdata", ram_wdata, 32'hA5A5A5A5);
    run_wait(1, en_cycles);
    step();

    // Half load with wait states, upper lane
    ram_rdata = 32'h9ABC1234;
    issue(1, 0, 2'b01, 0, 10'h00A, 32'h0);
    check("lh_ram_be", 32'(ram_be), 32'hC);
    check("lh_ram_addr", 32'(ram_addr), 32'h2);
    run_wait(3, en_cycles);
    check("lh_en_cycles", 32'(en_cycles), 32'd3);
    check("lh_load_data", load_data, 32'hFFFF9ABC);
    step();

    // Misaligned / illegal requests
    issue(1, 0, 2'b10, 0, 10'h002, 32'h0);
    run_wait(1, en_cycles);
    check("mis_w_en", 32'(en_cycles), 32'd0);
    check("mis_w_err", {30'd0, err_misalign, err_timeout}, 32'h2);
    check("mis_w_load", load_data, 32'd0);
    step();
    check("mis_w_pulse", 32'(resp_valid), 32'd0);
    issue(0, 1, 2'b01, 0, 10'h001, 32'h0);
    run_wait(1, en_cycles);
    check("mis_h_en", 32'(en_cycles), 32'd0);
    check("mis_h_err", {30'd0, err_misalign, err_timeout}, 32'h2);
    step();
    issue(0, 1, 2'b11, 0, 10'h000, 32'h0);
    run_wait(1, en_cycles);
    check("mis_sz3_en", 32'(en_cycles), 32'd0);
    check("mis_sz3_err", {30'd0, err_misalign, err_timeout}, 32'h2);
    step();
    issue(1, 1, 2'b10, 0, 10'h000, 32'h0);
    run_wait(1, en_cycles);
    check("both_dir_en", 32'(en_cycles), 32'd0);
    check("both_dir_err", {30'd0, err_misalign, err_timeout}, 32'h2);
    step();

    // Timeout, then recovery
    ram_rdata = 32'h55555555;
    issue(1, 0, 2'b10, 0, 10'h004, 32'h0);
    run_wait(0, en_cycles);
    check("to_en_cycles", 32'(en_cycles), 32'(MAX_WAIT));
    check("to_err", {30'd0, err_misalign, err_timeout}, 32'h1);
    check("to_load", load_data, 32'd0);
    step();
    ram_rdata = 32'h12345678;
    issue(1, 0, 2'b10, 0, 10'h008, 32'h0);
    run_wait(1, en_cycles);
    check("rec_load", load_data, 32'h12345678);
    check("rec_errs", {30'd0, err_misalign, err_timeout}, 32'd0);
    step();

    // Reset during the second WAIT cycle
    issue(1, 0, 2'b10, 0, 10'h00C, 32'h0);
    step();
    check("rw_en_before", 32'(ram_en), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rw_en_async", 32'(ram_en), 32'd0);
    check("rw_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    ram_ready = 1'b1;
    resp_seen = 1'b0;
    repeat (5) begin
      step();
      resp_seen |= resp_valid;
    end
    ram_ready = 1'b0;
    check("rw_no_resp", 32'(resp_seen), 32'd0);
    check("rw_req_ready_after", 32'(req_ready), 32'd1);
    check("rw_load_cleared", load_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
